wb_regfile: RTL and testbench

Writeback stage and architectural register file, directly downstream of the memory stage. Consumes the memory stage's `mem_to_wb_t` output and commits `result` to the 32-entry integer register file. Serves the decode stage's two combinational read ports, counts retired instructions and emits a registered one-cycle commit trace for the testbench and debug.

---
 rtl/wb_regfile_if.sv | 43 ++++
 rtl/wb_regfile.sv | 105 ++++++++++
 tb/tb_wb_regfile.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Retire-bus types and the writeback/register-file interface between the
// memory stage, the decode read ports and the commit trace consumers.
package wb_regfile_pkg;

   typedef logic [31:0] bus32_t;

   typedef struct packed {
      logic       valid;
      logic       write_rd;
      logic [4:0] rd;
   } instr_t;

   typedef struct packed {
      instr_t instr;
      bus32_t result;
   } mem_to_wb_t;

endpackage

interface wb_regfile_if;
   import wb_regfile_pkg::*;

   mem_to_wb_t  mem_to_wb_i;
   logic [4:0]  rs1_addr_i;
   logic [4:0]  rs2_addr_i;
   bus32_t      rs1_data_o;
   bus32_t      rs2_data_o;
   logic [63:0] instret_o;
   logic        retire_o;
   logic [4:0]  retire_rd_o;
   bus32_t      retire_data_o;

   modport master (
      output mem_to_wb_i, rs1_addr_i, rs2_addr_i,
      input  rs1_data_o, rs2_data_o, instret_o, retire_o, retire_rd_o, retire_data_o
   );

   modport slave (
      input  mem_to_wb_i, rs1_addr_i, rs2_addr_i,
      output rs1_data_o, rs2_data_o, instret_o, retire_o, retire_rd_o, retire_data_o
   );

endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: commits results to the integer register file, counts retirements
// and emits a one-cycle commit trace. Define TARTARUGA_WB_BYPASS_EN for write-through reads.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int XLEN     = 32
) (
   input logic         clk_i,
   input logic         rst_i,
   wb_regfile_if.slave wb
);

   localparam int AW = $clog2(NUM_REGS);

   logic [XLEN-1:0] regs_q [NUM_REGS];
   logic [XLEN-1:0] regs_d [NUM_REGS];
   logic [63:0]     instret_q;
   logic [63:0]     instret_d;
   logic            retire_q;
   logic            retire_d;
   logic [4:0]      retire_rd_q;
   logic [4:0]      retire_rd_d;
   logic [XLEN-1:0] retire_data_q;
   logic [XLEN-1:0] retire_data_d;

   logic            valid;
   logic            wen;
   logic [4:0]      rd;
   logic [AW-1:0]   rd_idx;
   logic [AW-1:0]   rs1_idx;
   logic [AW-1:0]   rs2_idx;
   logic [XLEN-1:0] result;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;

   assign valid   = wb.mem_to_wb_i.instr.valid;
   assign rd      = wb.mem_to_wb_i.instr.rd;
   assign result  = wb.mem_to_wb_i.result;
   assign wen     = valid & wb.mem_to_wb_i.instr.write_rd & (rd != 5'd0);
   assign rd_idx  = rd[AW-1:0];
   assign rs1_idx = wb.rs1_addr_i[AW-1:0];
   assign rs2_idx = wb.rs2_addr_i[AW-1:0];

   // Next-state: commit, retirement count and trace all derive from the same retiring slot.
   always_comb begin
      regs_d = regs_q;
      if (wen) begin
         regs_d[rd_idx] = result;
      end
      instret_d     = valid ? instret_q + 64'd1 : instret_q;
      retire_d      = valid;
      retire_rd_d   = wen ? rd : 5'd0;
      retire_data_d = wen ? result : '0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         regs_q        <= '{default: '0};
         instret_q     <= '0;
         retire_q      <= 1'b0;
         retire_rd_q   <= '0;
         retire_data_q <= '0;
      end else begin
         regs_q        <= regs_d;
         instret_q     <= instret_d;
         retire_q      <= retire_d;
         retire_rd_q   <= retire_rd_d;
         retire_data_q <= retire_data_d;
      end
   end

   // Reads are masked during reset so a pending bypass cannot leak a discarded result.
   always_comb begin
      rs1_data = '0;
      if (!rst_i && wb.rs1_addr_i != 5'd0) begin
         rs1_data = regs_q[rs1_idx];
`ifdef TARTARUGA_WB_BYPASS_EN
         if (wen && wb.rs1_addr_i == rd) begin
            rs1_data = result;
         end
`endif
      end
   end

   always_comb begin
      rs2_data = '0;
      if (!rst_i && wb.rs2_addr_i != 5'd0) begin
         rs2_data = regs_q[rs2_idx];
`ifdef TARTARUGA_WB_BYPASS_EN
         if (wen && wb.rs2_addr_i == rd) begin
            rs2_data = result;
         end
`endif
      end
   end

   assign wb.rs1_data_o    = rs1_data;
   assign wb.rs2_data_o    = rs2_data;
   assign wb.instret_o     = instret_q;
   assign wb.retire_o      = retire_q;
   assign wb.retire_rd_o   = retire_rd_q;
   assign wb.retire_data_o = retire_data_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed corner cases plus random retire
// traffic, compared against an architectural model of the register file.
module tb_wb_regfile;

`ifdef TARTARUGA_WB_BYPASS_EN
   localparam bit bypassEn = 1'b1;
`else
   localparam bit bypassEn = 1'b0;
`endif

   logic clk;
   logic rst;

   wb_regfile_if bus ();

   wb_regfile dut (
      .clk_i (clk),
      .rst_i (rst),
      .wb    (bus.slave)
   );

   int assertCount;
   int failCount;

   logic [31:0] modelRegs [32];
   logic [63:0] modelInstret;
   logic        modelRetire;
   logic [4:0]  modelRetireRd;
   logic [31:0] modelRetireData;

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so a broken design can never hang the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Architectural view of a read port: x0 is zero, reset clears everything,
   // and with write-through the retiring value wins.
   function automatic logic [31:0] expRead(input logic [4:0] addr, input logic v, input logic w,
                                           input logic [4:0] rd, input logic [31:0] res);
      if (rst || addr == 5'd0) return 32'd0;
      if (bypassEn && v && w && rd == addr) return res;
      return modelRegs[addr];
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
      modelInstret    = 64'd0;
      modelRetire     = 1'b0;
      modelRetireRd   = 5'd0;
      modelRetireData = 32'd0;
   endtask

   task automatic checkTrace(input string tag);
      checkOutput({tag, "_instret"}, bus.instret_o, modelInstret);
      checkOutput({tag, "_retire"}, {63'd0, bus.retire_o}, {63'd0, modelRetire});
      checkOutput({tag, "_retire_rd"}, {59'd0, bus.retire_rd_o}, {59'd0, modelRetireRd});
      checkOutput({tag, "_retire_data"}, {32'd0, bus.retire_data_o}, {32'd0, modelRetireData});
   endtask

   // One retiring slot: drive at negedge, check reads before the edge, trace after it.
   task automatic applyStimulus(input string tag, input logic v, input logic w, input logic [4:0] rd,
                                input logic [31:0] res, input logic [4:0] a1, input logic [4:0] a2);
      @(negedge clk);
      bus.mem_to_wb_i.instr.valid    = v;
      bus.mem_to_wb_i.instr.write_rd = w;
      bus.mem_to_wb_i.instr.rd       = rd;
      bus.mem_to_wb_i.result         = res;
      bus.rs1_addr_i                 = a1;
      bus.rs2_addr_i                 = a2;
      #2;
      checkOutput({tag, "_rs1"}, {32'd0, bus.rs1_data_o}, {32'd0, expRead(a1, v, w, rd, res)});
      checkOutput({tag, "_rs2"}, {32'd0, bus.rs2_data_o}, {32'd0, expRead(a2, v, w, rd, res)});
      @(posedge clk);
      if (v) modelInstret = modelInstret + 64'd1;
      if (v && w && rd != 5'd0) modelRegs[rd] = res;
      modelRetire     = v;
      modelRetireRd   = (v && w && rd != 5'd0) ? rd : 5'd0;
      modelRetireData = (v && w && rd != 5'd0) ? res : 32'd0;
      #1;
      checkTrace(tag);
   endtask

   task automatic idleBus();
      bus.mem_to_wb_i.instr.valid    = 1'b0;
      bus.mem_to_wb_i.instr.write_rd = 1'b0;
      bus.mem_to_wb_i.instr.rd       = 5'd0;
      bus.mem_to_wb_i.result         = 32'd0;
   endtask

   initial begin
      logic       v;
      logic       w;
      logic [4:0] rd;
      logic [4:0] a1;
      logic [4:0] a2;

      assertCount = 0;
      failCount   = 0;
      modelReset();
      rst = 1'b1;
      idleBus();
      bus.rs1_addr_i = 5'd5;
      bus.rs2_addr_i = 5'd31;

      // Power-on reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkTrace("por");
      checkOutput("por_rs1", {32'd0, bus.rs1_data_o}, 64'd0);
      rst = 1'b0;

      // Write to x0 is discarded but still retires.
      applyStimulus("x0_write", 1'b1, 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
      applyStimulus("x0_read", 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

      // Same-cycle read of the register being retired.
      applyStimulus("x7_seed", 1'b1, 1'b1, 5'd7, 32'h0000_0001, 5'd0, 5'd0);
      applyStimulus("x7_same", 1'b1, 1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7);
      applyStimulus("x7_next", 1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);

      // Asynchronous reset mid-cycle with a write pending.
      @(negedge clk);
      bus.mem_to_wb_i.instr.valid    = 1'b1;
      bus.mem_to_wb_i.instr.write_rd = 1'b1;
      bus.mem_to_wb_i.instr.rd       = 5'd9;
      bus.mem_to_wb_i.result         = 32'hCAFE_F00D;
      bus.rs1_addr_i                 = 5'd7;
      bus.rs2_addr_i                 = 5'd9;
      #2;
      rst = 1'b1;
      modelReset();
      #1;
      checkTrace("async_rst");
      checkOutput("async_rst_rs1", {32'd0, bus.rs1_data_o}, 64'd0);
      checkOutput("async_rst_rs2", {32'd0, bus.rs2_data_o}, 64'd0);
      @(posedge clk);
      #1;
      checkTrace("rst_edge");
      @(negedge clk);
      rst = 1'b0;
      idleBus();
      applyStimulus("post_rst_x5", 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd9, 5'd5);
      checkOutput("post_rst_instret", bus.instret_o, 64'd1);
      applyStimulus("post_rst_read", 1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd9);

      // Bubble pattern: valid, bubble, valid without write, write to x31.
      applyStimulus("bub_v", 1'b1, 1'b1, 5'd3, 32'h0000_0033, 5'd3, 5'd31);
      applyStimulus("bub_i", 1'b0, 1'b1, 5'd4, 32'h0000_0044, 5'd4, 5'd3);
      applyStimulus("bub_nw", 1'b1, 1'b0, 5'd6, 32'h0000_0066, 5'd6, 5'd4);
      applyStimulus("bub_x31", 1'b1, 1'b1, 5'd31, 32'h3131_3131, 5'd31, 5'd6);
      checkOutput("bub_instret", bus.instret_o, 64'd4);

      // Counter wrap via backdoor preload.
      @(negedge clk);
      idleBus();
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.instret_q;
      #1;
      modelInstret = 64'hFFFF_FFFF_FFFF_FFFF;
      checkOutput("wrap_preload", bus.instret_o, modelInstret);
      applyStimulus("wrap", 1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      checkOutput("wrap_zero", bus.instret_o, 64'd0);

      // Back-to-back writes to every register, then read them all back.
      for (int i = 0; i < 32; i++) begin
         applyStimulus($sformatf("fill%0d", i), 1'b1, 1'b1, 5'(i), 32'h100 + 32'(i), 5'(i), 5'(31 - i));
      end
      for (int i = 0; i < 32; i++) begin
         applyStimulus($sformatf("readback%0d", i), 1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
         checkOutput($sformatf("readback_abs%0d", i), {32'd0, bus.rs1_data_o},
                     (i == 0) ? 64'd0 : 64'h100 + 64'(i));
      end

      // Random retire traffic with frequent read-after-retire collisions.
      for (int n = 0; n < 300; n++) begin
         v  = ($urandom_range(0, 3) != 0);
         w  = $urandom_range(0, 1) == 1;
         rd = 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
         applyStimulus("rand", v, w, rd, $urandom, a1, a2);
      end

      @(negedge clk);
      idleBus();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
